// File: rtl/sparse_sram_ctrl.sv
// sparse_sram_ctrl: associative {tag, data} memory with byte-enable writes,
// read-miss fill, valid/ready handshake, flush and table-full error.
module sparse_sram_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 50,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_be,
    input  logic                         flush,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_hit,
    output logic                         rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);
    localparam int BE_W = DATA_W / 8;
    localparam int OFF = $clog2(BE_W);
    localparam int TAG_W = ADDR_W - OFF;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, err_q, err_d;
    logic [TAG_W-1:0]  tag_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic              hit, free, lookup, commit, alloc, idle_flush;
    logic [IDX_W-1:0]  hit_idx, free_idx, widx;
    logic [DATA_W-1:0] base, merged;
    logic              unused_addr;

    assign unused_addr = ^req_addr;
    assign req_ready   = rst_n && state_q == IDLE && !flush;
    assign rsp_valid   = state_q == RESP;
    assign rsp_rdata   = rdata_q;
    assign rsp_hit     = hit_q;
    assign rsp_err     = err_q;
    assign count       = count_q;
    assign full        = count_q == CNT_W'(DEPTH);

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_mem_q[i] == tag_q) begin
                hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign base = hit ? data_mem_q[hit_idx] : FILL;

    always_comb begin
        merged = base;
        for (int b = 0; b < BE_W; b++)
            merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : base[8*b +: 8];
    end

    assign lookup     = state_q == LOOKUP;
    assign idle_flush = state_q == IDLE && flush;
    assign commit     = lookup && we_q && (hit || free);
    assign alloc      = commit && !hit;
    assign widx       = hit ? hit_idx : free_idx;
    assign rdata_d    = commit ? merged : (hit ? base : FILL);
    assign err_d      = we_q && !hit && !free;
    assign count_d    = idle_flush ? '0 : count_q + CNT_W'(alloc);

    always_comb begin
        state_d = state_q == IDLE   ? ((req_valid && !flush) ? LOOKUP : IDLE) :
                  state_q == LOOKUP ? RESP : (rsp_ready ? IDLE : RESP);
        valid_d = idle_flush ? '0 : valid_q;
        if (alloc) valid_d[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            count_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            tag_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            count_q <= count_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                tag_q   <= req_addr[ADDR_W-1:OFF];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (lookup) begin
                rdata_q <= rdata_d;
                hit_q   <= hit;
                err_q   <= err_d;
            end
        end
    end

    // Entry payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (commit) begin
            tag_mem_q[widx]  <= tag_q;
            data_mem_q[widx] <= merged;
        end
    end
endmodule

// File: tb/tb_sparse_sram_ctrl.sv
// tb_sparse_sram_ctrl: directed checks on two instances (FILL=0 and FILL=A5A5A5A5)
// driven with identical stimulus.
module tb_sparse_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_hit, rsp_err, full;
    logic [31:0] rsp_rdata;
    logic [2:0]  count;
    logic        req_ready_b, rsp_valid_b, rsp_hit_b, rsp_err_b, full_b;
    logic [31:0] rsp_rdata_b;
    logic [2:0]  count_b;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    sparse_sram_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .FILL(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err), .count(count), .full(full));

    sparse_sram_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .FILL(32'hA5A5A5A5)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .flush(flush), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_hit(rsp_hit_b), .rsp_err(rsp_err_b), .count(count_b), .full(full_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one request from IDLE and stop once the response is presented.
    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wd;
        req_be = be;
        #1 chk("req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        chk("lat_t1", rsp_valid, 0);
        @(posedge clk);
        #1 chk("lat_t2", rsp_valid, 1);
    endtask

    task automatic done();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    task automatic rsp(input string tag, input logic [31:0] rd, input logic hit,
                       input logic err, input logic [2:0] cnt);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_hit"}, rsp_hit, hit);
        chk({tag, "_err"}, rsp_err, err);
        chk({tag, "_count"}, count, cnt);
    endtask

    initial begin
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(0, 32'h100, 0, 0);
        rsp("rd_empty", 32'h0, 0, 0, 0);
        done();

        op(1, 32'h200, 32'h0000_00FF, 4'h1);
        rsp("fill0", 32'h0000_00FF, 0, 0, 1);
        chk("fillA5_rdata", rsp_rdata_b, 32'hA5A5_A5FF);
        chk("fillA5_hit", rsp_hit_b, 0);
        done();

        op(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        rsp("wr100", 32'hDEAD_BEEF, 0, 0, 2);
        done();
        op(0, 32'h100, 0, 0);
        rsp("rd100", 32'hDEAD_BEEF, 1, 0, 2);
        done();
        op(0, 32'h103, 0, 0);
        rsp("rd103", 32'hDEAD_BEEF, 1, 0, 2);
        done();

        op(1, 32'h100, 32'h1122_3344, 4'h3);
        rsp("merge", 32'hDEAD_3344, 1, 0, 2);
        done();

        op(1, 32'h300, 32'h1234_5678, 4'hF);
        rsp("wr300", 32'h1234_5678, 0, 0, 3);
        chk("full3", full, 0);
        done();
        op(1, 32'h400, 32'hCAFE_F00D, 4'hF);
        rsp("wr400", 32'hCAFE_F00D, 0, 0, 4);
        chk("full4", full, 1);
        done();
        op(1, 32'h500, 32'h5555_5555, 4'hF);
        rsp("wr_full", 32'h0, 0, 1, 4);
        done();
        op(1, 32'h300, 32'h0000_AAAA, 4'h2);
        rsp("wr_hit_full", 32'h1234_AA78, 1, 0, 4);
        done();
        op(0, 32'h500, 0, 0);
        rsp("rd500", 32'h0, 0, 0, 4);
        done();

        op(0, 32'h400, 0, 0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("bp_ready", req_ready, 0);
        end
        done();

        flush = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h600;
        req_wdata = 32'h7777_7777;
        req_be = 4'hF;
        #1 chk("flush_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_full", full, 0);
        chk("flush_noreq", rsp_valid, 0);
        @(posedge clk);
        #1 chk("flush_noreq2", rsp_valid, 0);
        op(0, 32'h600, 0, 0);
        rsp("rd600", 32'h0, 0, 0, 0);
        chk("rd600_b", rsp_rdata_b, 32'hA5A5_A5A5);
        done();
        op(0, 32'h100, 0, 0);
        rsp("rd100_flushed", 32'h0, 0, 0, 0);
        done();

        op(1, 32'h700, 32'h8888_8888, 4'hF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_count", count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op(0, 32'h700, 0, 0);
        rsp("rd700", 32'h0, 0, 0, 0);
        done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end
endmodule
